// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter that shares one DATA_W-bit output channel between
// NUM_REQ requesters. The winner's index drives the shared data mux (sel_o)
// and a one-hot grant goes back to the requesters. An owner keeps the channel
// for at most MAX_HOLD accepted beats, then the channel is re-arbitrated.
// Every release costs exactly one IDLE cycle before the next grant.
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   DATA_W    width of each requester word and of data_o
//   MAX_HOLD  accepted beats per grant before a forced release (>= 1)
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    synchronous active-high reset
//   req_i    per-requester request, held while the requester has data
//   data_i   packed requester data, requester k at [k*DATA_W +: DATA_W]
//   ready_i  downstream accepts data_o this cycle
//   grant_o  registered one-hot grant (zero when idle)
//   sel_o    registered owner index (holds its value through IDLE)
//   data_o   owner's data slice while busy, zero otherwise
//   valid_o  owner is still requesting while busy
//   busy_o   arbiter is in the BUSY state
//
// Build option:
//   MUX_RR_ARBITER_FIXED_PRIO_EN  when defined, the lowest-index active
//   requester always wins and the rotation pointer is not kept. Port list and
//   timing are the same in both builds.
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int  NUM_REQ  = 4,
    parameter int  DATA_W   = 8,
    parameter int  MAX_HOLD = 16,
    localparam int SEL_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    input  logic                      ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [SEL_W-1:0]          sel_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      valid_o,
    output logic                      busy_o
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic [SEL_W-1:0]     sel_d;
    logic [CNT_W-1:0]     beat_cnt;
    logic [CNT_W-1:0]     beat_cnt_d;
    logic [SEL_W-1:0]     winner;
    logic [SEL_W-1:0]     scan_idx;
    logic                 owner_req;
    logic                 beat;
    logic                 last_beat;
    logic                 arb_win;

    // Owner's request doubles as valid; a beat is a valid word the sink takes.
    assign owner_req = req_i[sel_o];
    assign busy_o    = (state_q == BUSY);
    assign valid_o   = busy_o & owner_req;
    assign beat      = valid_o & ready_i;
    assign last_beat = beat & (beat_cnt == LAST_BEAT);
    assign arb_win   = (state_q == IDLE) & (|req_i);

    // Shared output mux, forced to zero outside BUSY.
    always_comb begin
        data_o = '0;
        if (busy_o) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (sel_o == SEL_W'(k)) begin
                    data_o = data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
    // Fixed priority: descending scan so the lowest active index is kept last.
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = SEL_W'(i);
            if (req_i[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end
`else
    logic [SEL_W-1:0] last_ptr;

    // Round robin: scan offsets NUM_REQ..1 from last_ptr; the smallest offset
    // (the requester right after the previous owner) is assigned last and wins.
    // The previous owner itself sits at offset NUM_REQ, i.e. lowest priority.
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            scan_idx = SEL_W'((int'(last_ptr) + i) % NUM_REQ);
            if (req_i[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // Reset to NUM_REQ-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_ptr <= SEL_W'(NUM_REQ - 1);
        end else if (arb_win) begin
            last_ptr <= winner;
        end
    end
`endif

    // Next-state logic: grant on any request in IDLE, release on request drop
    // or on the final beat of the hold window. ready_i low freezes the count.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_o;
        sel_d      = sel_o;
        beat_cnt_d = beat_cnt;
        if (state_q == IDLE) begin
            if (arb_win) begin
                state_d    = BUSY;
                grant_d    = NUM_REQ'(1) << winner;
                sel_d      = winner;
                beat_cnt_d = '0;
            end
        end else begin
            if (!owner_req || last_beat) begin
                state_d    = IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
            end else if (beat) begin
                beat_cnt_d = beat_cnt + CNT_W'(1);
            end
        end
    end

    // State register boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_o  <= '0;
            sel_o    <= '0;
            beat_cnt <= '0;
        end else begin
            state_q  <= state_d;
            grant_o  <= grant_d;
            sel_o    <= sel_d;
            beat_cnt <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//
// Drives three arbiters (MAX_HOLD 16, 4 and 2) from one shared stimulus.
// A cycle-level model tracks owner, rotation pointer and beat count per
// instance; the DUT outputs are compared against it every cycle. A grant log
// built from the DUT outputs (owner, beats, start cycle per grant) is checked
// against hand-derived literals for each directed scenario.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int NI   = 3;
    localparam int LOGN = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] data;
    logic          ready;

    logic [N-1:0]  grant_w [NI];
    logic [1:0]    sel_w   [NI];
    logic [DW-1:0] data_w  [NI];
    logic          valid_w [NI];
    logic          busy_w  [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state per instance
    bit m_busy [NI];
    int m_sel  [NI];
    int m_last [NI];
    int m_cnt  [NI];

    // Grant log observed from the DUT outputs
    int          log_n     [NI];
    int          log_own   [NI][LOGN];
    int          log_beats [NI][LOGN];
    int          log_start [NI][LOGN];
    logic [N-1:0] prev_grant [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int H = (g == 0) ? 16 : ((g == 1) ? 4 : 2);
        mux_rr_arbiter #(
            .NUM_REQ  (N),
            .DATA_W   (DW),
            .MAX_HOLD (H)
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .req_i   (req),
            .data_i  (data),
            .ready_i (ready),
            .grant_o (grant_w[g]),
            .sel_o   (sel_w[g]),
            .data_o  (data_w[g]),
            .valid_o (valid_w[g]),
            .busy_o  (busy_w[g])
        );
    end

    function automatic int hold_of(input int g);
        return (g == 0) ? 16 : ((g == 1) ? 4 : 2);
    endfunction

    // Who wins an arbitration, straight from the priority rule.
    function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model update on each rising edge (inputs change 1 time unit later).
    initial begin
        for (int g = 0; g < NI; g++) begin
            m_busy[g] = 0; m_sel[g] = 0; m_last[g] = N - 1; m_cnt[g] = 0;
            log_n[g] = 0; prev_grant[g] = '0;
        end
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int g = 0; g < NI; g++) begin
                if (rst) begin
                    m_busy[g] = 0; m_sel[g] = 0; m_last[g] = N - 1; m_cnt[g] = 0;
                end else if (!m_busy[g]) begin
                    if (req != '0) begin
                        m_sel[g]  = pick(req, m_last[g]);
                        m_last[g] = m_sel[g];
                        m_busy[g] = 1;
                        m_cnt[g]  = 0;
                    end
                end else if (!req[m_sel[g]]) begin
                    m_busy[g] = 0;
                    m_cnt[g]  = 0;
                end else if (ready) begin
                    if (m_cnt[g] == hold_of(g) - 1) begin
                        m_busy[g] = 0;
                        m_cnt[g]  = 0;
                    end else begin
                        m_cnt[g] = m_cnt[g] + 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison and grant logging on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                for (int g = 0; g < NI; g++) begin
                    logic [N-1:0]  e_grant;
                    logic [DW-1:0] e_data;
                    logic          e_valid;
                    int            own;
                    e_grant = m_busy[g] ? (N'(1) << m_sel[g]) : '0;
                    e_valid = m_busy[g] && req[m_sel[g]];
                    e_data  = m_busy[g] ? data[m_sel[g]*DW +: DW] : '0;
                    chk($sformatf("grant[%0d] c%0d", g, cyc), 32'(grant_w[g]), 32'(e_grant));
                    chk($sformatf("sel[%0d] c%0d", g, cyc), 32'(sel_w[g]), 32'(m_sel[g]));
                    chk($sformatf("data[%0d] c%0d", g, cyc), 32'(data_w[g]), 32'(e_data));
                    chk($sformatf("valid[%0d] c%0d", g, cyc), 32'(valid_w[g]), 32'(e_valid));
                    chk($sformatf("busy[%0d] c%0d", g, cyc), 32'(busy_w[g]), 32'(m_busy[g]));
                    if (grant_w[g] != '0 && grant_w[g] !== prev_grant[g] && log_n[g] < LOGN) begin
                        own = -1;
                        for (int b = 0; b < N; b++) if (grant_w[g][b]) own = (own < 0) ? b : 99;
                        log_own[g][log_n[g]]   = own;
                        log_beats[g][log_n[g]] = 0;
                        log_start[g][log_n[g]] = cyc;
                        log_n[g] = log_n[g] + 1;
                    end
                    if (valid_w[g] === 1'b1 && ready && log_n[g] > 0)
                        log_beats[g][log_n[g]-1] = log_beats[g][log_n[g]-1] + 1;
                    prev_grant[g] = grant_w[g];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ready = 1'b0;
        tick(); tick();
        for (int g = 0; g < NI; g++) begin
            log_n[g] = 0; prev_grant[g] = '0;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; ready = 1'b0; data = '0;

        // ---- Reset state, then req 0101 with an owner drop after 3 beats
        do_reset();
        data = 32'h44332211;
        @(negedge clk);
        chk("rst_grant", 32'(grant_w[0]), 32'h0);
        chk("rst_sel",   32'(sel_w[0]),   32'h0);
        chk("rst_busy",  32'(busy_w[0]),  32'h0);
        chk("rst_valid", 32'(valid_w[0]), 32'h0);
        chk("rst_data",  32'(data_w[0]),  32'h0);
        tick();
        req = 4'b0101; ready = 1'b1;
        @(negedge clk);
        chk("t1_no_grant_yet", 32'(grant_w[0]), 32'h0);
        tick();
        @(negedge clk);
        chk("t1_grant0", 32'(grant_w[0]), 32'b0001);
        chk("t1_sel0",   32'(sel_w[0]),   32'h0);
        chk("t1_valid",  32'(valid_w[0]), 32'h1);
        chk("t1_data",   32'(data_w[0]),  32'h11);
        tick(); tick(); tick();
        req = 4'b0100;
        @(negedge clk);
        chk("t1_drop_valid", 32'(valid_w[0]), 32'h0);
        tick();
        @(negedge clk);
        chk("t1_dead_grant", 32'(grant_w[0]), 32'h0);
        chk("t1_dead_busy",  32'(busy_w[0]),  32'h0);
        chk("t1_dead_sel",   32'(sel_w[0]),   32'h0);
        tick();
        @(negedge clk);
        chk("t1_grant2", 32'(grant_w[0]), 32'b0100);
        chk("t1_sel2",   32'(sel_w[0]),   32'h2);
        chk("t1_data2",  32'(data_w[0]),  32'h33);
        tick();
        req = '0;
        tick(); tick();
        chk("t1_log_n",   32'(log_n[0]),        32'd2);
        chk("t1_own0",    32'(log_own[0][0]),   32'd0);
        chk("t1_beats0",  32'(log_beats[0][0]), 32'd3);
        chk("t1_own1",    32'(log_own[0][1]),   32'd2);
        chk("t1_beats1",  32'(log_beats[0][1]), 32'd1);

        // ---- All four requesting, MAX_HOLD 4 instance
        do_reset();
        req = 4'b1111; ready = 1'b1;
        repeat (23) tick();
        req = '0;
        tick(); tick();
        chk("t2_log_n", 32'(log_n[1] >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
            chk($sformatf("t2_own%0d", i), 32'(log_own[1][i]), 32'd0);
`else
            chk($sformatf("t2_own%0d", i), 32'(log_own[1][i]), 32'(i % 4));
`endif
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_beats%0d", i), 32'(log_beats[1][i]), 32'd4);
            chk($sformatf("t2_gap%0d", i), 32'(log_start[1][i+1] - log_start[1][i]), 32'd5);
        end

        // ---- Owner 1 stalled by ready low for 10 cycles, then one beat
        do_reset();
        data = 32'h0000A500; req = 4'b0010; ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t3_valid%0d", i), 32'(valid_w[0]), 32'h1);
            chk($sformatf("t3_data%0d", i),  32'(data_w[0]),  32'hA5);
            chk($sformatf("t3_grant%0d", i), 32'(grant_w[0]), 32'b0010);
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        @(negedge clk);
        chk("t3_still_granted", 32'(grant_w[0]), 32'b0010);
        req = '0;
        tick(); tick();
        chk("t3_log_n",  32'(log_n[0]),        32'd1);
        chk("t3_beats",  32'(log_beats[0][0]), 32'd1);

        // ---- Reset mid-burst (owner 2 after 2 beats), then req 0110
        do_reset();
        data = 32'h44332211; req = 4'b0100; ready = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t4_pre_busy", 32'(busy_w[0]), 32'h1);
        tick();
        rst = 1'b0; req = 4'b0110;
        @(negedge clk);
        chk("t4_rst_grant", 32'(grant_w[0]), 32'h0);
        chk("t4_rst_valid", 32'(valid_w[0]), 32'h0);
        chk("t4_rst_busy",  32'(busy_w[0]),  32'h0);
        tick();
        @(negedge clk);
        chk("t4_grant1", 32'(grant_w[0]), 32'b0010);
        chk("t4_sel1",   32'(sel_w[0]),   32'h1);
        tick();
        req = '0;
        tick(); tick();

        // ---- Single requester 3 on the MAX_HOLD 2 instance
        do_reset();
        req = 4'b1000; ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("t5_sel%0d", i), 32'(sel_w[2]), 32'h3);
        end
        tick();
        req = '0;
        tick(); tick();
        chk("t5_log_n", 32'(log_n[2] >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_own%0d", i),   32'(log_own[2][i]),   32'd3);
            chk($sformatf("t5_beats%0d", i), 32'(log_beats[2][i]), 32'd2);
            chk($sformatf("t5_gap%0d", i), 32'(log_start[2][i+1] - log_start[2][i]), 32'd3);
        end

        // ---- req 1001 on the MAX_HOLD 2 instance, then requester 0 leaves
        do_reset();
        req = 4'b1001; ready = 1'b1;
        repeat (12) tick();
        req = 4'b1000;
        repeat (8) tick();
        req = '0;
        tick(); tick();
        chk("t6_log_n", 32'(log_n[2] >= 5), 32'd1);
        for (int i = 0; i < 4; i++) begin
`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
            chk($sformatf("t6_own%0d", i), 32'(log_own[2][i]), 32'd0);
`else
            chk($sformatf("t6_own%0d", i), 32'(log_own[2][i]), 32'((i % 2) * 3));
`endif
        end
        chk("t6_own4", 32'(log_own[2][4]), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
